// File: rtl/double_add_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, non-stallable double adder between two
// requesters, with per-requester credits guaranteeing response FIFO space for every result.
module double_add_arbiter #(
   parameter int LATENCY    = 14,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [63:0] req0_a,
   input  logic [63:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [63:0] req1_a,
   input  logic [63:0] req1_b,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [63:0] rsp0_data,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [63:0] rsp1_data,
   output logic [63:0] add_dataa,
   output logic [63:0] add_datab,
   input  logic [63:0] add_result,
   output logic        add_dummy_enable
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [1:0]        req_valid_v;
   logic [1:0]        rsp_ready_v;
   logic [1:0]        cred_full;
   logic [1:0]        elig;
   logic [1:0]        grant;
   logic [1:0]        rsp_valid_v;
   logic [1:0][63:0]  rsp_data_v;
   logic              grant_any;
   logic              prio;
   logic [LATENCY-1:0] tag_valid;
   logic [LATENCY-1:0] tag_id;

   assign req_valid_v = {req1_valid, req0_valid};
   assign rsp_ready_v = {rsp1_ready, rsp0_ready};

   // Grants are forced low while reset is asserted so no handshake can be seen during reset.
   always_comb begin
      elig     = req_valid_v & ~cred_full;
      grant    = 2'b00;
      grant[0] = reset_n && elig[0] && (!elig[1] || !prio);
      grant[1] = reset_n && elig[1] && (!elig[0] || prio);
   end

   assign grant_any        = |grant;
   assign req0_ready       = grant[0];
   assign req1_ready       = grant[1];
   assign add_dummy_enable = grant_any;
   assign add_dataa        = grant[0] ? req0_a : (grant[1] ? req1_a : 64'd0);
   assign add_datab        = grant[0] ? req0_b : (grant[1] ? req1_b : 64'd0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prio <= 1'b0;
      end else if (grant_any) begin
         prio <= grant[0];
      end
   end

   // Tag pipeline mirrors the adder latency so the final stage lines up with add_result.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tag_valid <= '0;
         tag_id    <= '0;
      end else begin
         tag_valid <= {tag_valid[LATENCY-2:0], grant_any};
         tag_id    <= {tag_id[LATENCY-2:0], grant[1]};
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_rsp
      logic [63:0]   mem [FIFO_DEPTH];
      logic [PW-1:0] wr_ptr;
      logic [PW-1:0] rd_ptr;
      logic [CW-1:0] count;
      logic [CW-1:0] cred;
      logic          wr;
      logic          pop;
      logic          empty;
      logic          full;

      assign wr    = tag_valid[LATENCY-1] && (tag_id[LATENCY-1] == 1'(i));
      assign empty = (count == '0);
      assign full  = (count == CW'(FIFO_DEPTH));
      assign pop   = !empty && rsp_ready_v[i];

      assign cred_full[i]   = (cred >= CW'(FIFO_DEPTH));
      assign rsp_valid_v[i] = !empty;
      assign rsp_data_v[i]  = empty ? 64'd0 : mem[rd_ptr];

      always_ff @(posedge clock) begin
         if (wr) begin
            mem[wr_ptr] <= add_result;
         end
      end

      // Credit covers both in-flight ops and queued results, so it only drops on a pop.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            cred   <= '0;
         end else begin
            if (wr) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(wr) - CW'(pop);
            cred  <= cred + CW'(grant[i]) - CW'(pop);
         end
      end

      a_no_overflow : assert property (@(posedge clock) disable iff (!reset_n)
         !(wr && full && !pop));
   end

   assign rsp0_valid = rsp_valid_v[0];
   assign rsp1_valid = rsp_valid_v[1];
   assign rsp0_data  = rsp_data_v[0];
   assign rsp1_data  = rsp_data_v[1];

endmodule
